// File: rtl/seq_alu_pkg.sv
// Shared opcode encodings, handshake FSM states and helpers for the sequential ALU.
package seq_alu_pkg;

  typedef logic [3:0] op_t;

  localparam op_t OP_ADD   = 4'd0;
  localparam op_t OP_SUB   = 4'd1;
  localparam op_t OP_AND   = 4'd2;
  localparam op_t OP_OR    = 4'd3;
  localparam op_t OP_XOR   = 4'd4;
  localparam op_t OP_SLT   = 4'd5;
  localparam op_t OP_SLTU  = 4'd6;
  localparam op_t OP_SLL   = 4'd7;
  localparam op_t OP_SRL   = 4'd8;
  localparam op_t OP_SRA   = 4'd9;
  localparam op_t OP_MUL   = 4'd10;
  localparam op_t OP_MULHU = 4'd11;
  localparam op_t OP_DIVU  = 4'd12;
  localparam op_t OP_REMU  = 4'd13;

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_e;

  typedef enum logic [1:0] {MD_MUL, MD_MULHU, MD_DIVU, MD_REMU} md_op_e;

  function automatic logic is_iterative(input op_t op);
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Radix-2 iterative engine: shift-add multiply and restoring divide, one step per enabled cycle.
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             en,
  input  md_op_e           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  // Upper half: partial product / remainder; lower half: multiplier bits / quotient.
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   b_q;
  md_op_e             op_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH:0]     acc, diff;
  logic [WIDTH-1:0]   addend;

  always_comb begin
    acc    = '0;
    diff   = '0;
    addend = '0;
    p_d    = p_q;
    if (op_q == MD_MUL || op_q == MD_MULHU) begin
      addend = p_q[0] ? b_q : '0;
      acc    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
      p_d    = {acc, p_q[WIDTH-1:1]};
    end else begin
      acc  = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
      diff = acc - {1'b0, b_q};
      // A zero divisor never borrows, so the quotient fills with ones and A shifts into the remainder.
      if (!diff[WIDTH]) p_d = {diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
      else              p_d = {acc[WIDTH-1:0],  p_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    result = '0;
    unique case (op_q)
      MD_MUL:   result = p_d[WIDTH-1:0];
      MD_MULHU: result = p_d[2*WIDTH-1:WIDTH];
      MD_DIVU:  result = p_d[WIDTH-1:0];
      MD_REMU:  result = p_d[2*WIDTH-1:WIDTH];
      default:  result = '0;
    endcase
  end

  assign done = en && (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q   <= '0;
      b_q   <= '0;
      op_q  <= MD_MUL;
      cnt_q <= '0;
    end else if (start) begin
      p_q   <= {{WIDTH{1'b0}}, a};
      b_q   <= b;
      op_q  <= op;
      cnt_q <= '0;
    end else if (en) begin
      p_q   <= p_d;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Execute-stage ALU with valid/ready handshake; single-cycle ops register at accept, MUL/DIV iterate.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned OP_W  = 4,
  localparam int unsigned SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_illegal
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, ill_q, ill_d;

  op_t              op;
  logic             accept, iter;
  logic [WIDTH:0]   sum;
  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_o, alu_ill;
  md_op_e           md_op;
  logic             md_done;
  logic [WIDTH-1:0] md_res;

  assign op        = op_t'(in_op);
  assign shamt     = in_b[SH_W-1:0];
  assign iter      = is_iterative(op);
  assign out_valid = (state_q == HOLD);
  assign in_ready  = (state_q != BUSY) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;

  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    alu_ill = 1'b0;
    unique case (op)
      OP_ADD: begin
        sum     = {1'b0, in_a} + {1'b0, in_b};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_o   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (alu_res[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        sum     = {1'b0, in_a} - {1'b0, in_b};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_o   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (alu_res[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      OP_SLL:  alu_res = in_a << shamt;
      OP_SRL:  alu_res = in_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(in_a) >>> shamt);
      OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    md_op = MD_MUL;
    unique case (op)
      OP_MULHU: md_op = MD_MULHU;
      OP_DIVU:  md_op = MD_DIVU;
      OP_REMU:  md_op = MD_REMU;
      default:  md_op = MD_MUL;
    endcase
  end

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (accept && iter),
    .en     (state_q == BUSY),
    .op     (md_op),
    .a      (in_a),
    .b      (in_b),
    .done   (md_done),
    .result (md_res)
  );

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    ill_d   = ill_q;
    unique case (state_q)
      IDLE, HOLD: begin
        if (accept) begin
          if (iter) begin
            state_d = BUSY;
          end else begin
            state_d = HOLD;
            res_d   = alu_res;
            zero_d  = (alu_res == '0);
            carry_d = alu_c;
            ovf_d   = alu_o;
            ill_d   = alu_ill;
          end
        end else if (state_q == HOLD && out_ready) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (md_done) begin
          state_d = HOLD;
          res_d   = md_res;
          zero_d  = (md_res == '0);
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          ill_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      ill_q   <= ill_d;
    end
  end

  assign out_result  = res_q;
  assign out_zero    = zero_q;
  assign out_carry   = carry_q;
  assign out_ovf     = ovf_q;
  assign out_illegal = ill_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu at WIDTH=32 and WIDTH=8 against an arithmetic reference model.
module tb_seq_alu;

  localparam logic [3:0] T_ADD = 4'd0, T_SUB = 4'd1, T_AND = 4'd2, T_XOR = 4'd4,
                         T_SLT = 4'd5, T_SLTU = 4'd6, T_SRA = 4'd9, T_MUL = 4'd10,
                         T_MULHU = 4'd11, T_DIVU = 4'd12, T_REMU = 4'd13, T_BAD = 4'd15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [3:0]  in_op = '0;
  logic [31:0] in_a = '0, in_b = '0;
  logic        out_ready = 1'b0;
  logic        sel8 = 1'b0;

  logic        rdy32, v32, z32, c32, o32, i32;
  logic [31:0] r32;
  logic        rdy8, v8, z8, c8, o8, i8;
  logic [7:0]  r8;

  logic        o_rdy, o_v, o_z, o_c, o_o, o_i;
  logic [31:0] o_r;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32), .OP_W(4)) u_dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .out_valid(v32), .out_ready(out_ready), .out_result(r32),
    .out_zero(z32), .out_carry(c32), .out_ovf(o32), .out_illegal(i32)
  );

  seq_alu #(.WIDTH(8), .OP_W(4)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy8), .in_op(in_op),
    .in_a(in_a[7:0]), .in_b(in_b[7:0]), .out_valid(v8), .out_ready(out_ready), .out_result(r8),
    .out_zero(z8), .out_carry(c8), .out_ovf(o8), .out_illegal(i8)
  );

  always_comb begin
    o_rdy = sel8 ? rdy8 : rdy32;
    o_v   = sel8 ? v8   : v32;
    o_r   = sel8 ? {24'b0, r8} : r32;
    o_z   = sel8 ? z8   : z32;
    o_c   = sel8 ? c8   : c32;
    o_o   = sel8 ? o8   : o32;
    o_i   = sel8 ? i8   : i32;
  end

  function automatic void model(input int w, input logic [3:0] op,
                                input longint unsigned a0, input longint unsigned b0,
                                output longint unsigned r, output logic c, output logic o,
                                output logic z, output logic il);
    longint unsigned m, a, b, full;
    longint sa, sb, t, lo, hi;
    int sh;
    m  = (64'd1 << w) - 64'd1;
    a  = a0 & m;
    b  = b0 & m;
    sa = (((a >> (w - 1)) & 64'd1) != 0) ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb = (((b >> (w - 1)) & 64'd1) != 0) ? longint'(b) - (longint'(1) << w) : longint'(b);
    lo = -(longint'(1) << (w - 1));
    hi = (longint'(1) << (w - 1)) - 1;
    sh = int'(b % longint'(w));
    r = 0; c = 0; o = 0; il = 0;
    case (op)
      4'd0:  begin full = a + b; r = full & m; c = (full >> w) != 0; t = sa + sb; o = (t < lo) || (t > hi); end
      4'd1:  begin r = (a - b) & m; c = (a < b); t = sa - sb; o = (t < lo) || (t > hi); end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = (sa < sb) ? 1 : 0;
      4'd6:  r = (a < b) ? 1 : 0;
      4'd7:  r = (a << sh) & m;
      4'd8:  r = a >> sh;
      4'd9:  begin t = sa >>> sh; r = t & m; end
      4'd10: r = (a * b) & m;
      4'd11: r = (a * b) >> w;
      4'd12: r = (b == 0) ? m : a / b;
      4'd13: r = (b == 0) ? a : a % b;
      default: il = 1;
    endcase
    z = (r == 0);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!o_rdy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "/ready"}, o_rdy, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One transaction: accept, measure latency, compare result/flags, then drain.
  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    longint unsigned er;
    logic ec, eo, ez, ei, it, busy_ok;
    int w, lat;
    w  = sel8 ? 8 : 32;
    it = (op >= T_MUL) && (op <= T_REMU);
    model(w, op, {32'b0, a}, {32'b0, b}, er, ec, eo, ez, ei);
    wait_ready(tag);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1; busy_ok = 1'b1;
    while (!o_v && lat < 100) begin
      if (o_rdy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "/lat"}, lat, it ? w + 1 : 1);
    if (it) chk({tag, "/busy_ready"}, busy_ok, 1);
    chk({tag, "/result"}, o_r, er);
    chk({tag, "/flags"}, {o_z, o_c, o_o, o_i}, {ez, ec, eo, ei});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "/drained"}, o_v, 0);
  endtask

  initial begin
    logic [31:0] ra, rb, hold;
    logic [3:0]  rop;
    longint unsigned er;
    logic ec, eo, ez, ei, stale;

    do_reset();
    chk("reset/valid", o_v, 0);
    chk("reset/result", o_r, 0);
    chk("reset/flags", {o_z, o_c, o_o, o_i}, 4'b0000);
    chk("reset/ready", o_rdy, 1);

    run(T_ADD, 32'hFFFF_FFFF, 32'h1, "add_wrap");
    chk("add_wrap/const", {o_r, o_z, o_c, o_o}, {32'h0, 3'b110});
    run(T_SUB, 32'h8000_0000, 32'h1, "sub_ovf");
    chk("sub_ovf/const", {o_r, o_o}, {32'h7FFF_FFFF, 1'b1});
    run(T_SLT, 32'hFFFF_FFFF, 32'h1, "slt");
    chk("slt/const", o_r, 32'h1);
    run(T_SLTU, 32'hFFFF_FFFF, 32'h1, "sltu");
    chk("sltu/const", o_r, 32'h0);
    run(T_SRA, 32'h8000_0000, 32'h21, "sra");
    chk("sra/const", o_r, 32'hC000_0000);
    run(T_MUL, 32'h1_0000, 32'h1_0000, "mul");
    chk("mul/const", o_r, 32'h0);
    run(T_MULHU, 32'h1_0000, 32'h1_0000, "mulhu");
    chk("mulhu/const", o_r, 32'h1);
    run(T_DIVU, 32'd100, 32'd7, "divu");
    chk("divu/const", o_r, 32'd14);
    run(T_REMU, 32'd100, 32'd7, "remu");
    chk("remu/const", o_r, 32'd2);
    run(T_DIVU, 32'd5, 32'd0, "divu_zero");
    chk("divu_zero/const", o_r, 32'hFFFF_FFFF);
    run(T_REMU, 32'd5, 32'd0, "remu_zero");
    chk("remu_zero/const", o_r, 32'd5);
    run(T_BAD, 32'h1234, 32'h5678, "illegal");
    chk("illegal/const", {o_r, o_i}, {32'h0, 1'b1});

    // Back-to-back single-cycle ops, then a stalled consumer.
    wait_ready("b2b");
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rop = (k == 0) ? T_ADD : (k == 1) ? T_XOR : T_AND;
      ra = $urandom; rb = $urandom;
      in_valid = 1'b1; in_op = rop; in_a = ra; in_b = rb;
      @(posedge clk); #1;
      model(32, rop, {32'b0, ra}, {32'b0, rb}, er, ec, eo, ez, ei);
      chk($sformatf("b2b%0d/valid", k), o_v, 1);
      chk($sformatf("b2b%0d/result", k), o_r, er);
    end
    hold = o_r;
    out_ready = 1'b0;
    in_op = T_ADD; in_a = $urandom; in_b = $urandom;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d/state", k), {o_v, o_rdy, o_r}, {1'b1, 1'b0, hold});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    for (int k = 0; k < 30; k++) begin
      rop = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      run(rop, ra, rb, $sformatf("rnd32_%0d_op%0d", k, rop));
    end

    // Reset while the divider is iterating.
    wait_ready("rst_busy");
    in_valid = 1'b1; in_op = T_DIVU; in_a = 32'd1000; in_b = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_busy/valid", o_v, 0);
    chk("rst_busy/ready", o_rdy, 1);
    stale = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (o_v) stale = 1'b1;
    end
    chk("rst_busy/no_stale", stale, 0);

    do_reset();
    sel8 = 1'b1;
    chk("w8_reset/ready", o_rdy, 1);
    run(T_MUL, 32'h10, 32'h10, "w8_mul");
    chk("w8_mul/const", o_r, 32'h0);
    run(T_DIVU, 32'd200, 32'd0, "w8_divu_zero");
    for (int k = 0; k < 12; k++) begin
      rop = 4'($urandom_range(0, 15));
      run(rop, $urandom, 32'($urandom_range(0, 255)), $sformatf("rnd8_%0d_op%0d", k, rop));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, handshaked successor to the CPU datapath's combinational ALU. It adds shifts, unsigned compare, carry/overflow flags and iterative multiply/divide, and registers every result. It sits in the execute stage between operand latch and writeback, using valid/ready on both sides so the pipeline stalls while a MUL/DIV is iterating.

Parameters:
WIDTH, 32, operand/result width in bits (>=8, power of two)
OP_W, 4, opcode width
SH_W, $clog2(WIDTH), shift-amount width (derived; not overridden)

Ports:
clk  in  1  clock, rising-edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  operands/op presented
in_ready  out  1  block can accept
in_op  in  OP_W  operation code
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
out_valid  out  1  result presented
out_ready  in  1  consumer accepts result
out_result  out  WIDTH  result
out_zero  out  1  out_result == 0
out_carry  out  1  ADD carry-out / SUB borrow (A<B unsigned); 0 otherwise
out_ovf  out  1  signed overflow for ADD/SUB; 0 otherwise
out_illegal  out  1  opcode undefined

Behaviour:
- One clock. Reset is synchronous and active-high. Ports are named clk and reset.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 MUL (low WIDTH bits), 11 MULHU (high WIDTH bits, unsigned), 12 DIVU, 13 REMU. Opcodes 14 and 15 are illegal: result 0, out_illegal=1, 1-cycle path.
- Shift opcodes use in_b[SH_W-1:0]. Upper bits of B are ignored.
- Compare results are zero-extended 1 or 0.
- States: IDLE, BUSY, HOLD.
- Accept: transfer occurs when in_valid && in_ready. in_ready = (state!=BUSY) && (!out_valid || out_ready).
- Single-cycle ops: result, flags and out_valid are registered at the accept edge. Latency is 1 cycle. Back-to-back accepts give 1 result per cycle.
- MUL/MULHU/DIVU/REMU: the accept edge latches operands and enters BUSY with count=0. Each cycle runs one radix-2 step (shift-add or restoring subtract), count++. After WIDTH steps the result is registered and out_valid rises. Latency is WIDTH+1 cycles from accept. in_ready stays 0 throughout BUSY.
- Divide by zero: DIVU returns all-ones and REMU returns A. No exception. Latency is unchanged (still iterates).
- Output hold: while out_valid && !out_ready (state HOLD or registered output), all out_* are stable and in_ready=0. Transfer occurs on out_valid && out_ready. When simultaneous with a new accept, the new result replaces the old one on the same edge with no bubble.
- Flags are computed from the final result. For MUL/DIV, out_carry=out_ovf=0.
- Arithmetic wraps modulo 2^WIDTH.
- Reset (any state, including mid-BUSY): state=IDLE, count=0, out_valid=0, out_result=0, all flags 0, in_ready=1 in the cycle after reset deasserts. Any in-flight operation is discarded.
- in_* values are don't-care when in_valid=0. Outputs change only on accept, BUSY completion, or reset.

Decomposition:
- Package seq_alu_pkg: opcode localparams (OP_ADD..OP_REMU), state enum (IDLE/BUSY/HOLD), a function is_iterative(op).
- Sub-module seq_alu_muldiv: iterative radix-2 multiply/divide engine with start/done, WIDTH-parametrised. The top level holds the handshake FSM and the single-cycle datapath.

Test Plan:
- Reset then ADD 0xFFFFFFFF+1 -> after 1 cycle: result 0, zero=1, carry=1, ovf=0. SUB 0x80000000-1 -> 0x7FFFFFFF, ovf=1.
- SLT A=0xFFFFFFFF, B=1 -> 1. SLTU same operands -> 0. SRA 0x80000000 by B=0x21 (shamt 1) -> 0xC0000000.
- MUL 0x10000 x 0x10000 -> low 0, out_valid exactly 33 cycles after accept, in_ready low meanwhile. MULHU same operands -> 1.
- DIVU 100/7 -> 14. REMU 100/7 -> 2. DIVU 5/0 -> 0xFFFFFFFF. REMU 5/0 -> 5.
- Back-to-back ADD, XOR, AND with out_ready=1 -> 3 results on 3 consecutive cycles. Then out_ready=0 for 4 cycles -> result held stable, in_ready=0.
- Assert reset at BUSY cycle 10 of DIVU -> next cycle out_valid=0, in_ready=1. No stale result emitted. Opcode 15 -> result 0, illegal=1. Repeat at WIDTH=8: MUL latency is 9 cycles.
